// File: rtl/dmem_access_ctrl_pkg.sv
// Shared definitions for the data-memory load/store unit.
//   - memory command encodings driven on dm_ctrl_sig
//   - FSM state encodings
//   - latched request payload
package dmem_access_ctrl_pkg;

    localparam int unsigned DMEM_DEPTH  = 256;
    localparam int unsigned DMEM_DATA_W = 128;
    localparam int unsigned DMEM_ADDR_W = 32;
    localparam int unsigned DMEM_MASK_W = DMEM_DATA_W / 8;
    localparam int unsigned DM_CTRL_W   = 2;

    // Memory command encodings
    localparam logic [DM_CTRL_W-1:0] MEMNOP = 2'b00;
    localparam logic [DM_CTRL_W-1:0] MEMWLD = 2'b01;
    localparam logic [DM_CTRL_W-1:0] MEMWST = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_RESP = 3'd4
    } state_e;

    typedef struct packed {
        logic                   store;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] wdata;
        logic [DMEM_MASK_W-1:0] bmask;
    } dmem_req_t;

endpackage

// File: rtl/wide_byte_merge.sv
// Byte-lane select: each output byte comes from new_i where mask_i is set,
// otherwise from old_i.
//   old_i    : word read back from memory
//   new_i    : store data
//   mask_i   : byte enables, bit i covers bits [8i +: 8]
//   merged_o : combined word
module wide_byte_merge #(
    parameter int unsigned DATA_W = 128
) (
    input  logic [DATA_W-1:0]   old_i,
    input  logic [DATA_W-1:0]   new_i,
    input  logic [DATA_W/8-1:0] mask_i,
    output logic [DATA_W-1:0]   merged_o
);

    localparam int unsigned MASK_W = DATA_W / 8;

    always_comb begin
        merged_o = old_i;
        for (int i = 0; i < MASK_W; i++) begin
            if (mask_i[i]) begin
                merged_o[8*i +: 8] = new_i[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Load/store unit driving the data memory. One request at a time over a
// valid/ready handshake; partial stores are read-modify-write.
//   clk, reset              : clock, synchronous active-high reset
//   req_*                   : request channel (store flag, word address, data, byte mask)
//   rsp_*                   : response channel (load data, address error)
//   dm_ctrl_sig             : memory command (MEMWLD / MEMWST / MEMNOP)
//   mem_ctrl_addr           : memory word address
//   dm_data_in / dm_data_out: memory write / read data
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = DMEM_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_store,
    input  logic [DMEM_ADDR_W-1:0] req_addr,
    input  logic [DMEM_DATA_W-1:0] req_wdata,
    input  logic [DMEM_MASK_W-1:0] req_bmask,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DMEM_DATA_W-1:0] rsp_data,
    output logic                   rsp_err,
    output logic [DM_CTRL_W-1:0]   dm_ctrl_sig,
    output logic [DMEM_ADDR_W-1:0] mem_ctrl_addr,
    output logic [DMEM_DATA_W-1:0] dm_data_in,
    input  logic [DMEM_DATA_W-1:0] dm_data_out
);

    state_e                 state_q, state_d;
    dmem_req_t              req_q, req_d;
    logic [DM_CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic [DMEM_ADDR_W-1:0] addr_q, addr_d;
    logic [DMEM_DATA_W-1:0] wdata_q, wdata_d;
    logic [DMEM_DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic                   rsp_err_q, rsp_err_d;
    logic                   req_ready_q, req_ready_d;

    logic                   accept_c;
    logic                   addr_err_c;
    logic                   full_mask_c;
    logic                   empty_mask_c;
    logic [DMEM_DATA_W-1:0] merged_c;

    // Full-width compare so high address bits can never alias into range
    assign accept_c     = (state_q == ST_IDLE) && req_valid && req_ready_q;
    assign addr_err_c   = req_addr >= DMEM_ADDR_W'(DEPTH);
    assign full_mask_c  = &req_bmask;
    assign empty_mask_c = ~|req_bmask;

    wide_byte_merge #(
        .DATA_W (DMEM_DATA_W)
    ) u_merge (
        .old_i    (dm_data_out),
        .new_i    (req_q.wdata),
        .mask_i   (req_q.bmask),
        .merged_o (merged_c)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    if (addr_err_c)                    state_d = ST_RESP;
                    else if (req_store && full_mask_c)  state_d = ST_WR;
                    else if (req_store && empty_mask_c) state_d = ST_RESP;
                    else                                state_d = ST_RD;
                end
            end
            ST_RD:   state_d = ST_CAP;
            ST_CAP:  state_d = req_q.store ? ST_WR : ST_RESP;
            ST_WR:   state_d = ST_RESP;
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output/datapath next values; flags are decoded from the next state so
    // the registered outputs line up with the state they belong to.
    always_comb begin
        req_d       = req_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        rsp_valid_d = (state_d == ST_RESP);
        req_ready_d = (state_d == ST_IDLE);
        case (state_d)
            ST_RD:   ctrl_d = MEMWLD;
            ST_WR:   ctrl_d = MEMWST;
            default: ctrl_d = MEMNOP;
        endcase

        if (accept_c) begin
            req_d.store = req_store;
            req_d.addr  = req_addr;
            req_d.wdata = req_wdata;
            req_d.bmask = req_bmask;
            addr_d      = req_addr;
            rsp_err_d   = addr_err_c;
            rsp_data_d  = '0;
            if (req_store && full_mask_c) begin
                wdata_d = req_wdata;
            end
        end

        // dm_data_out holds the word read during RD
        if (state_q == ST_CAP) begin
            if (req_q.store) wdata_d    = merged_c;
            else             rsp_data_d = dm_data_out;
        end
    end

    // Output and request registers
    always_ff @(posedge clk) begin
        if (reset) begin
            req_q       <= '0;
            ctrl_q      <= MEMNOP;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b0;
        end else begin
            req_q       <= req_d;
            ctrl_q      <= ctrl_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            req_ready_q <= req_ready_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_err       = rsp_err_q;
    assign dm_ctrl_sig   = ctrl_q;
    assign mem_ctrl_addr = addr_q;
    assign dm_data_in    = wdata_q;

endmodule
